// File: rtl/wb_pkg.sv
// Shared types and constants for the dual-PE writeback arbiter and its pending-write queue.
package wb_pkg;

   localparam int WB_DEPTH = 4;

   localparam logic RES_ALU = 1'b0;
   localparam logic RES_MEM = 1'b1;

   typedef struct packed {
      logic [4:0]  rd;
      logic [31:0] data;
   } wb_entry_t;

   typedef enum logic [1:0] {
      SEL_NONE,
      SEL_QUEUE,
      SEL_PE1,
      SEL_PE2
   } commit_sel_e;

   function automatic logic [31:0] select_result(input logic        src,
                                                 input logic [31:0] alu,
                                                 input logic [31:0] mem);
      return (src == RES_MEM) ? mem : alu;
   endfunction

endpackage

// File: rtl/writeback_arbiter_if.sv
// W-stage bundle of both PEs plus the shared register-file write port and queue status.
interface writeback_arbiter_if import wb_pkg::*; #(parameter int DEPTH = WB_DEPTH);

   logic                     RegWriteW1;
   logic                     RegWriteW2;
   logic                     ResultSrcW1;
   logic                     ResultSrcW2;
   logic [4:0]               RD_W1;
   logic [4:0]               RD_W2;
   logic [31:0]              ALU_ResultW1;
   logic [31:0]              ALU_ResultW2;
   logic [31:0]              ReadDataW1;
   logic [31:0]              ReadDataW2;
   logic [31:0]              ResultW1;
   logic [31:0]              ResultW2;
   logic                     RegWriteOut;
   logic [4:0]               RDOut;
   logic [31:0]              ResultOut;
   logic                     StallM;
   logic                     Busy;
   logic [$clog2(DEPTH):0]   Count;

   // Pipeline side: drives the W bundles, consumes forwarding/stall/write-port signals.
   modport master (
      output RegWriteW1, RegWriteW2, ResultSrcW1, ResultSrcW2,
             RD_W1, RD_W2, ALU_ResultW1, ALU_ResultW2, ReadDataW1, ReadDataW2,
      input  ResultW1, ResultW2, RegWriteOut, RDOut, ResultOut, StallM, Busy, Count
   );

   modport slave (
      input  RegWriteW1, RegWriteW2, ResultSrcW1, ResultSrcW2,
             RD_W1, RD_W2, ALU_ResultW1, ALU_ResultW2, ReadDataW1, ReadDataW2,
      output ResultW1, ResultW2, RegWriteOut, RDOut, ResultOut, StallM, Busy, Count
   );

endinterface

// File: rtl/wb_fifo.sv
// Circular buffer of pending register writes: two ordered push ports (push0 older), one pop port.
module wb_fifo import wb_pkg::*; #(
   parameter int DEPTH = WB_DEPTH
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   push0_valid,
   input  wb_entry_t              push0_data,
   input  logic                   push1_valid,
   input  wb_entry_t              push1_data,
   input  logic                   pop,
   output wb_entry_t              head_data,
   output logic [$clog2(DEPTH):0] count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [PW-1:0] head_q, head_d;
   logic [PW-1:0] tail_q, tail_d;
   logic [CW-1:0] count_q, count_d;
   logic [CW-1:0] n_push;

   logic          wr0_en, wr1_en;
   logic [PW-1:0] wr0_idx, wr1_idx;
   wb_entry_t     wr0_data, wr1_data;
   wb_entry_t     mem_rd [DEPTH];

   // Pushes are compacted so a lone push1 still lands at the tail.
   always_comb begin
      wr0_en   = push0_valid || push1_valid;
      wr0_data = push0_valid ? push0_data : push1_data;
      wr1_en   = push0_valid && push1_valid;
      wr1_data = push1_data;
      wr0_idx  = tail_q;
      wr1_idx  = tail_q + PW'(1);
      n_push   = CW'(push0_valid) + CW'(push1_valid);
      head_d   = head_q + PW'(pop);
      tail_d   = tail_q + n_push[PW-1:0];
      count_d  = count_q + n_push - CW'(pop);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   for (genvar gi = 0; gi < DEPTH; gi++) begin : g_mem
      wb_entry_t entry_q, entry_d;

      always_comb begin
         entry_d = entry_q;
         if (wr0_en && wr0_idx == PW'(gi)) entry_d = wr0_data;
         if (wr1_en && wr1_idx == PW'(gi)) entry_d = wr1_data;
      end

      always_ff @(posedge clk) begin
         entry_q <= entry_d;
      end

      assign mem_rd[gi] = entry_q;
   end

   assign head_data = mem_rd[head_q];
   assign count     = count_q;

endmodule

// File: rtl/writeback_arbiter.sv
// Serialises PE1/PE2 register writes onto one register-file port, buffering overflow writes.
// Optional WB_COALESCE_EN: same-rd dual writes drop the older PE1 write.
module writeback_arbiter import wb_pkg::*; #(
   parameter int DEPTH = WB_DEPTH
) (
   input logic                clk,
   input logic                rst,
   writeback_arbiter_if.slave wb
);

   localparam int CW = $clog2(DEPTH) + 1;

   logic [31:0]   result_w1, result_w2;
   logic [CW-1:0] count;
   logic          stall, busy;
   logic          v1_raw, v2_raw, v1, v2;
   commit_sel_e   sel;

   logic          push0_valid, push1_valid, pop;
   wb_entry_t     push0_data, push1_data, head_data;

   logic          reg_write_q, reg_write_d;
   logic [4:0]    rd_q, rd_d;
   logic [31:0]   result_q, result_d;

   assign result_w1 = select_result(wb.ResultSrcW1, wb.ALU_ResultW1, wb.ReadDataW1);
   assign result_w2 = select_result(wb.ResultSrcW2, wb.ALU_ResultW2, wb.ReadDataW2);

   // Status depends on occupancy only, so there is no input-to-StallM path.
   assign stall = (count == CW'(DEPTH));
   assign busy  = (count != '0);

   assign v1_raw = wb.RegWriteW1 && (wb.RD_W1 != 5'd0) && !stall;
   assign v2_raw = wb.RegWriteW2 && (wb.RD_W2 != 5'd0) && !stall;

`ifdef WB_COALESCE_EN
   assign v1 = v1_raw && !(v2_raw && (wb.RD_W1 == wb.RD_W2));
`else
   assign v1 = v1_raw;
`endif
   assign v2 = v2_raw;

   // Queue entries are always older than either live request.
   always_comb begin
      sel = SEL_NONE;
      if (busy)    sel = SEL_QUEUE;
      else if (v1) sel = SEL_PE1;
      else if (v2) sel = SEL_PE2;
   end

   always_comb begin
      push0_valid = v1 && (sel != SEL_PE1);
      push1_valid = v2 && (sel != SEL_PE2);
      push0_data  = '{rd: wb.RD_W1, data: result_w1};
      push1_data  = '{rd: wb.RD_W2, data: result_w2};
      pop         = (sel == SEL_QUEUE);
   end

   wb_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk         (clk),
      .rst         (rst),
      .push0_valid (push0_valid),
      .push0_data  (push0_data),
      .push1_valid (push1_valid),
      .push1_data  (push1_data),
      .pop         (pop),
      .head_data   (head_data),
      .count       (count)
   );

   always_comb begin
      reg_write_d = 1'b0;
      rd_d        = rd_q;
      result_d    = result_q;
      case (sel)
         SEL_QUEUE: begin
            reg_write_d = 1'b1;
            rd_d        = head_data.rd;
            result_d    = head_data.data;
         end
         SEL_PE1: begin
            reg_write_d = 1'b1;
            rd_d        = wb.RD_W1;
            result_d    = result_w1;
         end
         SEL_PE2: begin
            reg_write_d = 1'b1;
            rd_d        = wb.RD_W2;
            result_d    = result_w2;
         end
         default: reg_write_d = 1'b0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         reg_write_q <= 1'b0;
         rd_q        <= 5'd0;
         result_q    <= 32'd0;
      end else begin
         reg_write_q <= reg_write_d;
         rd_q        <= rd_d;
         result_q    <= result_d;
      end
   end

   assign wb.ResultW1    = result_w1;
   assign wb.ResultW2    = result_w2;
   assign wb.RegWriteOut = reg_write_q;
   assign wb.RDOut       = rd_q;
   assign wb.ResultOut   = result_q;
   assign wb.StallM      = stall;
   assign wb.Busy        = busy;
   assign wb.Count       = count;

endmodule

// File: tb/tb_writeback_arbiter.sv
// Directed bench for writeback_arbiter: single/dual writes, fill and stall, x0/same-rd, reset mid-drain.
module tb_writeback_arbiter;
   import wb_pkg::*;

   localparam int DEPTH = 4;

   logic clk = 1'b0;
   logic rst;
   int   total  = 0;
   int   passes = 0;

   always #5 clk = ~clk;

   writeback_arbiter_if #(.DEPTH(DEPTH)) wb_if ();

   writeback_arbiter #(.DEPTH(DEPTH)) dut (
      .clk (clk),
      .rst (rst),
      .wb  (wb_if)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passes++;
      else $error("FAIL %s: observed %h required %h", tag, obs, exp);
   endtask

   task automatic drive(input logic we1, input logic [4:0] rd1, input logic src1,
                        input logic [31:0] alu1, input logic [31:0] mem1,
                        input logic we2, input logic [4:0] rd2, input logic src2,
                        input logic [31:0] alu2, input logic [31:0] mem2);
      wb_if.RegWriteW1   = we1;
      wb_if.RD_W1        = rd1;
      wb_if.ResultSrcW1  = src1;
      wb_if.ALU_ResultW1 = alu1;
      wb_if.ReadDataW1   = mem1;
      wb_if.RegWriteW2   = we2;
      wb_if.RD_W2        = rd2;
      wb_if.ResultSrcW2  = src2;
      wb_if.ALU_ResultW2 = alu2;
      wb_if.ReadDataW2   = mem2;
   endtask

   task automatic idle();
      drive(0, 5'd0, 0, 32'd0, 32'd0, 0, 5'd0, 0, 32'd0, 32'd0);
   endtask

   // One clock; sample 1 time unit after the edge and log the write port.
   task automatic tick();
      @(posedge clk);
      #1;
      $display("t=%0t we=%0b rd=%0d data=%h count=%0d stall=%0b busy=%0b",
               $time, wb_if.RegWriteOut, wb_if.RDOut, wb_if.ResultOut,
               wb_if.Count, wb_if.StallM, wb_if.Busy);
      total++;
      assert (int'(wb_if.Count) <= DEPTH) passes++;
      else $error("FAIL count_bound: observed %0d required <= %0d", wb_if.Count, DEPTH);
   endtask

   task automatic chk_out(input string tag, input logic we, input logic [4:0] rd, input logic [31:0] data);
      chk({tag, "_we"},   32'(wb_if.RegWriteOut), 32'(we));
      chk({tag, "_rd"},   32'(wb_if.RDOut),       32'(rd));
      chk({tag, "_data"}, wb_if.ResultOut,        data);
   endtask

   task automatic chk_q(input string tag, input int cnt, input logic stall, input logic busy);
      chk({tag, "_count"}, 32'(wb_if.Count),  32'(cnt));
      chk({tag, "_stall"}, 32'(wb_if.StallM), 32'(stall));
      chk({tag, "_busy"},  32'(wb_if.Busy),   32'(busy));
   endtask

   initial begin
      rst = 1'b1;
      idle();
      tick();
      tick();
      rst = 1'b0;
      chk_out("reset", 0, 5'd0, 32'd0);
      chk_q("reset", 0, 0, 0);

      // Combinational result select
      drive(0, 5'd1, 1, 32'h11, 32'h22, 0, 5'd2, 0, 32'h33, 32'h44);
      #1;
      chk("resw1_mem", wb_if.ResultW1, 32'h22);
      chk("resw2_alu", wb_if.ResultW2, 32'h33);

      // Single write from PE1, then hold on idle
      drive(1, 5'd5, 0, 32'h1234, 32'hFFFF, 0, 5'd0, 0, 32'd0, 32'd0);
      tick();
      chk_out("single", 1, 5'd5, 32'h1234);
      chk_q("single", 0, 0, 0);
      idle();
      tick();
      chk_out("hold", 0, 5'd5, 32'h1234);

      // Dual write: PE1 first, PE2 from the queue next cycle
      drive(1, 5'd3, 1, 32'h0, 32'hAAAA_0001, 1, 5'd4, 0, 32'h55, 32'h0);
      tick();
      chk_out("dual1", 1, 5'd3, 32'hAAAA_0001);
      chk_q("dual1", 1, 0, 1);
      idle();
      tick();
      chk_out("dual2", 1, 5'd4, 32'h55);
      chk_q("dual2", 0, 0, 0);

      // Fill: four distinct pairs; commit j carries rd=10+j, data=0x100+j
      for (int i = 0; i < 4; i++) begin
         drive(1, 5'(10 + 2*i), 0, 32'(32'h100 + 2*i), 32'd0,
               1, 5'(11 + 2*i), 0, 32'(32'h101 + 2*i), 32'd0);
         tick();
         chk_out($sformatf("fill%0d", i), 1, 5'(10 + i), 32'(32'h100 + i));
         chk($sformatf("fill%0d_count", i), 32'(wb_if.Count), 32'(i + 1));
      end
      chk_q("full", 4, 1, 1);
      drive(1, 5'd20, 0, 32'hE0, 32'd0, 1, 5'd21, 0, 32'hE1, 32'd0);
      #1;
      chk("stall_held", 32'(wb_if.StallM), 32'd1);
      tick();
      chk_out("masked", 1, 5'd14, 32'h104);
      chk_q("masked", 3, 0, 1);
      idle();
      for (int i = 5; i < 8; i++) begin
         tick();
         chk_out($sformatf("drain%0d", i), 1, 5'(10 + i), 32'(32'h100 + i));
         chk($sformatf("drain%0d_count", i), 32'(wb_if.Count), 32'(7 - i));
      end
      tick();
      chk_out("drained", 0, 5'd17, 32'h107);
      chk_q("drained", 0, 0, 0);

      // x0 discarded
      drive(1, 5'd0, 0, 32'hDEAD, 32'd0, 1, 5'd7, 0, 32'h9, 32'd0);
      tick();
      chk_out("x0", 1, 5'd7, 32'h9);
      chk_q("x0", 0, 0, 0);

      // Same destination from both PEs
      drive(1, 5'd8, 0, 32'h1, 32'd0, 1, 5'd8, 0, 32'h2, 32'd0);
      tick();
`ifdef WB_COALESCE_EN
      chk_out("same_rd", 1, 5'd8, 32'h2);
      chk_q("same_rd", 0, 0, 0);
      idle();
      tick();
      chk_out("same_rd_idle", 0, 5'd8, 32'h2);
`else
      chk_out("same_rd1", 1, 5'd8, 32'h1);
      chk_q("same_rd1", 1, 0, 1);
      idle();
      tick();
      chk_out("same_rd2", 1, 5'd8, 32'h2);
      chk_q("same_rd2", 0, 0, 0);
`endif

      // Reset while three writes are pending
      for (int i = 0; i < 3; i++) begin
         drive(1, 5'(1 + 2*i), 0, 32'(32'h700 + 2*i), 32'd0,
               1, 5'(2 + 2*i), 0, 32'(32'h701 + 2*i), 32'd0);
         tick();
      end
      chk_q("pre_rst", 3, 0, 1);
      idle();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk_out("mid_rst", 0, 5'd0, 32'd0);
      chk_q("mid_rst", 0, 0, 0);
      for (int i = 0; i < 4; i++) begin
         tick();
         chk($sformatf("post_rst%0d_we", i), 32'(wb_if.RegWriteOut), 32'd0);
      end
      chk_q("post_rst", 0, 0, 0);

      $display("%0d/%0d checks passed", passes, total);
      $finish;
   end

endmodule
